// File: rtl/vga_text_renderer.sv
// vga_text_renderer
// Pixel stage behind the VGA sync generator. It renders an 80x30 text screen
// of 8x16 glyphs into 12-bit RGB (4:4:4). The screen also has a blinking
// underline cursor.
//
// The pipeline has four stages and moves only on clk edges with tick=1:
//   S0 register raster inputs
//   S1 character RAM read
//   S2 font ROM address out
//   S3 glyph bit select and colour mux
// hsync/vsync/video_on are delayed alongside so they stay aligned with rgb.
//
// Ports:
//   clk, reset (async, active-high), tick  pixel-advance qualifier
//   pixelx/pixely, video_on_i, hsync_i, vsync_i  raster from sync generator
//   wr_en/wr_addr/wr_data                       character RAM write port
//                                               (data [7]=invert, [6:0]=glyph)
//   wr_err                                      sticky out-of-range write flag
//   cursor_en/cursor_col/cursor_row             underline cursor control
//   font_addr/font_data                         external synchronous font ROM
//   rgb, hsync, vsync, video_on                 aligned outputs
module vga_text_renderer #(
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] CUR_COLOR    = 12'h0F0,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [9:0]  pixelx,
  input  logic [9:0]  pixely,
  input  logic        video_on_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_err,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on
);

  localparam int          STAGES    = 4;
  localparam int          CELLS     = 2400;
  localparam logic [11:0] LAST_CELL = 12'd2399;
  localparam logic [7:0]  BLINK_TOP = 8'(BLINK_FRAMES - 1);

  // Control bits ride a shift register. Index n is the copy held by stage Sn.
  logic [STAGES-1:0] vld_pipe, hs_pipe, vs_pipe;

  logic [9:0]  s0_x, s0_y;
  logic [2:0]  s1_x, s2_x;
  logic [3:0]  s1_y;
  logic        s1_cur, s2_cur, s2_inv;
  logic [7:0]  ram_q;
  logic        blink_phase;

  logic [6:0]  s0_col;
  logic [4:0]  s0_row;
  logic [11:0] rd_addr;
  logic        cur_match;
  logic        pix_bit;

  assign s0_col = s0_x[9:3];
  assign s0_row = s0_y[8:4];

  // The cell index is row*80 + col, built as row*64 + row*16 + col.
  // Off-screen rows and columns can go as high as 31*80+127. That still fits
  // in 12 bits, and video_on blanks those pixels anyway.
  assign rd_addr = {1'b0, s0_row, 6'b0} + {3'b0, s0_row, 4'b0} + {5'b0, s0_col};

  // The underline covers the bottom two glyph rows of the cursor cell.
  assign cur_match = cursor_en && (s0_col == cursor_col) && (s0_row == cursor_row)
                     && (s0_y[3:0] >= 4'd14);

  // font_data bit 7 is the leftmost pixel.
  assign pix_bit = font_data[3'd7 - s2_x] ^ s2_inv;

  // Character RAM. It has no reset. A read and a write to the same cell in
  // one clk return the old data, because the read samples before the NBA
  // update lands.
  logic [7:0] mem [CELLS];

  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr <= LAST_CELL))
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ram_q <= 8'h00;
    else if (tick)
      ram_q <= (rd_addr <= LAST_CELL) ? mem[rd_addr] : 8'h00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wr_err <= 1'b0;
    else if (wr_en && (wr_addr > LAST_CELL))
      wr_err <= 1'b1;
  end

  // Pixel pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      hs_pipe   <= '1;
      vs_pipe   <= '1;
      s0_x      <= '0;
      s0_y      <= '0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_cur    <= 1'b0;
      font_addr <= '0;
      s2_x      <= '0;
      s2_inv    <= 1'b0;
      s2_cur    <= 1'b0;
      rgb       <= '0;
    end else if (tick) begin
      vld_pipe  <= {vld_pipe[STAGES-2:0], video_on_i};
      hs_pipe   <= {hs_pipe[STAGES-2:0],  hsync_i};
      vs_pipe   <= {vs_pipe[STAGES-2:0],  vsync_i};
      // S0
      s0_x      <= pixelx;
      s0_y      <= pixely;
      // S1
      s1_x      <= s0_x[2:0];
      s1_y      <= s0_y[3:0];
      s1_cur    <= cur_match;
      // S2
      font_addr <= {ram_q[6:0], s1_y};
      s2_x      <= s1_x;
      s2_inv    <= ram_q[7];
      s2_cur    <= s1_cur;
      // S3
      if (!vld_pipe[2])
        rgb <= 12'h000;
      else if (s2_cur && blink_phase)
        rgb <= CUR_COLOR;
      else if (pix_bit)
        rgb <= FG_COLOR;
      else
        rgb <= BG_COLOR;
    end
  end

  assign video_on = vld_pipe[STAGES-1];
  assign hsync    = hs_pipe[STAGES-1];
  assign vsync    = vs_pipe[STAGES-1];

  // Cursor blink. This counts frames on every vsync_i falling edge, and it
  // keeps counting when tick is low and when the cursor is disabled.
  logic       vs_q;
  logic [7:0] blink_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q        <= 1'b1;
      blink_cnt   <= 8'd0;
      blink_phase <= 1'b1;
    end else begin
      vs_q <= vsync_i;
      if (vs_q && !vsync_i) begin
        if (blink_cnt == BLINK_TOP) begin
          blink_cnt   <= 8'd0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 8'd1;
        end
      end
    end
  end

endmodule
